// File: rtl/complex_butterfly_seq_if.sv
// Handshake and data bundle for the sequential complex butterfly.
// The producer and consumer of both handshakes sit on the master side.
interface complex_butterfly_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_real;
    logic [31:0] a_im;
    logic [31:0] b_real;
    logic [31:0] b_im;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum_real;
    logic [31:0] sum_im;
    logic [31:0] diff_real;
    logic [31:0] diff_im;

    modport master (
        output in_valid, a_real, a_im, b_real, b_im, out_ready,
        input  in_ready, out_valid, sum_real, sum_im, diff_real, diff_im
    );

    modport slave (
        input  in_valid, a_real, a_im, b_real, b_im, out_ready,
        output in_ready, out_valid, sum_real, sum_im, diff_real, diff_im
    );
endinterface

// File: rtl/complex_butterfly_seq.sv
// Radix-2 complex butterfly: A+B and A-B computed over four cycles on one
// shared binary32 adder (round-to-nearest-even, subnormals flushed to zero).
module Floating_adder (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        sub_i,
    input  logic        en_i,
    output logic [31:0] result_o
);
    logic        sa, sb, sl, ss, up;
    logic [7:0]  ea, eb, el, es, d;
    logic [23:0] ma, mb, ml, ms;
    logic [26:0] ml_x, ms_x, ms_full;
    logic [27:0] acc;
    logic [4:0]  lz;
    logic [9:0]  exp_w;
    logic [24:0] rnd;
    logic [22:0] frac;
    logic        nan_a, nan_b;

    always_comb begin
        sa = a_i[31];
        sb = b_i[31] ^ sub_i;
        ea = a_i[30:23];
        eb = b_i[30:23];
        ma = (ea == 8'd0) ? 24'd0 : {1'b1, a_i[22:0]};
        mb = (eb == 8'd0) ? 24'd0 : {1'b1, b_i[22:0]};
        if ({ea, ma} >= {eb, mb}) begin
            sl = sa; el = ea; ml = ma; ss = sb; es = eb; ms = mb;
        end else begin
            sl = sb; el = eb; ml = mb; ss = sa; es = ea; ms = ma;
        end
        d       = el - es;
        ml_x    = {ml, 3'b000};
        ms_full = {ms, 3'b000};
        // Three extra bits carry guard, round and a sticky OR of everything shifted out.
        if (d > 8'd26) begin
            ms_x = {26'd0, |ms};
        end else begin
            ms_x    = ms_full >> d;
            ms_x[0] = ms_x[0] | (|(ms_full & ((27'd1 << d) - 27'd1)));
        end
        if (sl == ss) acc = {1'b0, ml_x} + {1'b0, ms_x};
        else          acc = {1'b0, ml_x} - {1'b0, ms_x};
        exp_w = {2'b00, el};
        lz    = 5'd0;
        if (acc[27]) begin
            acc   = {1'b0, acc[27:2], acc[1] | acc[0]};
            exp_w = exp_w + 10'd1;
        end else begin
            for (int i = 0; i < 27; i++) begin
                if (acc[i]) lz = 5'(26 - i);
            end
            acc   = acc << lz;
            exp_w = exp_w - {5'd0, lz};
        end
        up  = acc[2] & (acc[1] | acc[0] | acc[3]);
        rnd = {1'b0, acc[26:3]} + {24'd0, up};
        if (rnd[24]) begin
            exp_w = exp_w + 10'd1;
            frac  = rnd[23:1];
        end else begin
            frac  = rnd[22:0];
        end
        if (acc == 28'd0)                    result_o = {sl & ss, 31'd0};
        else if (exp_w[9] || exp_w == 10'd0) result_o = {sl, 31'd0};
        else if (exp_w >= 10'd255)           result_o = {sl, 8'hFF, 23'd0};
        else                                 result_o = {sl, exp_w[7:0], frac};
        nan_a = (ea == 8'hFF) && (a_i[22:0] != 23'd0);
        nan_b = (eb == 8'hFF) && (b_i[22:0] != 23'd0);
        if (nan_a)                                     result_o = a_i | 32'h0040_0000;
        else if (nan_b)                                result_o = b_i | 32'h0040_0000;
        else if (ea == 8'hFF && eb == 8'hFF && sa != sb) result_o = 32'h7FC0_0000;
        else if (ea == 8'hFF)                          result_o = a_i;
        else if (eb == 8'hFF)                          result_o = {sb, b_i[30:0]};
        if (!en_i) result_o = 32'd0;
    end
endmodule

module complex_butterfly_seq (
    input  logic                          clk,
    input  logic                          rst_n,
    complex_butterfly_seq_if.slave        bus
);
    typedef enum logic [2:0] {ST_IDLE, ST_SR, ST_SI, ST_DR, ST_DI, ST_OUT} state_t;

    state_t      state_q, state_d;
    logic [31:0] a_re_q, a_im_q, b_re_q, b_im_q;
    logic [31:0] sum_re_q, sum_im_q, diff_re_q, diff_im_q;
    logic [31:0] op_a, op_b, add_res;
    logic        op_sub, accept;

    assign accept = (state_q == ST_IDLE) && bus.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        op_a    = a_re_q;
        op_b    = b_re_q;
        op_sub  = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.in_valid) state_d = ST_SR;
            ST_SR:   state_d = ST_SI;
            ST_SI: begin
                state_d = ST_DR;
                op_a    = a_im_q;
                op_b    = b_im_q;
            end
            ST_DR: begin
                state_d = ST_DI;
                op_sub  = 1'b1;
            end
            ST_DI: begin
                state_d = ST_OUT;
                op_a    = a_im_q;
                op_b    = b_im_q;
                op_sub  = 1'b1;
            end
            ST_OUT:  if (bus.out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    Floating_adder u_adder (
        .a_i      (op_a),
        .b_i      (op_b),
        .sub_i    (op_sub),
        .en_i     (1'b1),
        .result_o (add_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_re_q    <= 32'd0;
            a_im_q    <= 32'd0;
            b_re_q    <= 32'd0;
            b_im_q    <= 32'd0;
            sum_re_q  <= 32'd0;
            sum_im_q  <= 32'd0;
            diff_re_q <= 32'd0;
            diff_im_q <= 32'd0;
        end else begin
            if (accept) begin
                a_re_q <= bus.a_real;
                a_im_q <= bus.a_im;
                b_re_q <= bus.b_real;
                b_im_q <= bus.b_im;
            end
            if (state_q == ST_SR) sum_re_q  <= add_res;
            if (state_q == ST_SI) sum_im_q  <= add_res;
            if (state_q == ST_DR) diff_re_q <= add_res;
            if (state_q == ST_DI) diff_im_q <= add_res;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_OUT);
    assign bus.sum_real  = sum_re_q;
    assign bus.sum_im    = sum_im_q;
    assign bus.diff_real = diff_re_q;
    assign bus.diff_im   = diff_im_q;
endmodule

// File: tb/tb_complex_butterfly_seq.sv
// Directed bench for complex_butterfly_seq; expected results are hand-computed
// binary32 values for exactly representable operands.
module tb_complex_butterfly_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    complex_butterfly_seq_if bus ();

    complex_butterfly_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Back-to-back pairs: (3+1i)+-(1+1i), (-2+0.25i)+-(0.5-0.25i), (8+10i)+-(8+6i)
    localparam logic [31:0] P_AR [3] = '{32'h40400000, 32'hC0000000, 32'h41000000};
    localparam logic [31:0] P_AI [3] = '{32'h3F800000, 32'h3E800000, 32'h41200000};
    localparam logic [31:0] P_BR [3] = '{32'h3F800000, 32'h3F000000, 32'h41000000};
    localparam logic [31:0] P_BI [3] = '{32'h3F800000, 32'hBE800000, 32'h40C00000};
    localparam logic [31:0] E_SR [3] = '{32'h40800000, 32'hBFC00000, 32'h41800000};
    localparam logic [31:0] E_SI [3] = '{32'h40000000, 32'h00000000, 32'h41800000};
    localparam logic [31:0] E_DR [3] = '{32'h40000000, 32'hC0200000, 32'h00000000};
    localparam logic [31:0] E_DI [3] = '{32'h00000000, 32'h3F000000, 32'h40800000};

    // Present one pair for a single cycle; returns at the negedge after the accept edge.
    task automatic drive_pair(input logic [31:0] ar, input logic [31:0] ai,
                              input logic [31:0] br, input logic [31:0] bi);
        bus.a_real   = ar;
        bus.a_im     = ai;
        bus.b_real   = br;
        bus.b_im     = bi;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if ({bus.sum_real, bus.sum_im, bus.diff_real, bus.diff_im} !== 128'd0) begin
            errors++; $display("FAIL reset_results got %h %h %h %h want all 0", bus.sum_real, bus.sum_im, bus.diff_real, bus.diff_im);
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: in_ready=%b out_valid=%b", bus.in_ready, bus.out_valid);
    endtask

    task automatic test_basic;
        int n;
        bus.out_ready = 1'b1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b want 1", bus.in_ready); end
        drive_pair(32'h3F800000, 32'h40800000, 32'h40000000, 32'h3F000000);
        n = 1;  // the accept edge counts as the first edge
        while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
        checks++; if (n != 5) begin errors++; $display("FAIL basic_latency got %0d edges want 5", n); end
        checks++; if (bus.sum_real !== 32'h40400000) begin errors++; $display("FAIL basic_sum_real got %h want 40400000", bus.sum_real); end
        checks++; if (bus.sum_im !== 32'h40900000) begin errors++; $display("FAIL basic_sum_im got %h want 40900000", bus.sum_im); end
        checks++; if (bus.diff_real !== 32'hBF800000) begin errors++; $display("FAIL basic_diff_real got %h want bf800000", bus.diff_real); end
        checks++; if (bus.diff_im !== 32'h40600000) begin errors++; $display("FAIL basic_diff_im got %h want 40600000", bus.diff_im); end
        $display("basic: sum=%h,%h diff=%h,%h edges=%0d", bus.sum_real, bus.sum_im, bus.diff_real, bus.diff_im, n);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL basic_handshake got out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_backpressure;
        int n;
        bus.out_ready = 1'b0;
        drive_pair(32'h3F800000, 32'h40800000, 32'h40000000, 32'h3F000000);
        n = 1;
        while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout got out_valid=%b want 1", bus.out_valid); end
        for (int i = 0; i < 7; i++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d] got out_valid=%b in_ready=%b want 1/0", i, bus.out_valid, bus.in_ready);
            end
            checks++; if ({bus.sum_real, bus.sum_im, bus.diff_real, bus.diff_im} !== {32'h40400000, 32'h40900000, 32'hBF800000, 32'h40600000}) begin
                errors++; $display("FAIL bp_stable[%0d] got %h %h %h %h want 40400000 40900000 bf800000 40600000", i, bus.sum_real, bus.sum_im, bus.diff_real, bus.diff_im);
            end
            bus.a_real = 32'h40490FDB; bus.a_im = 32'h40490FDB;
            bus.b_real = 32'h40490FDB; bus.b_im = 32'h40490FDB;
            bus.in_valid = 1'b1;
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
        end
        checks++; if (bus.sum_real !== 32'h40400000) begin errors++; $display("FAIL bp_retained got %h want 40400000", bus.sum_real); end
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ignored_valid got in_ready=%b want 1", bus.in_ready); end
        $display("backpressure: held 7 cycles, sum=%h,%h diff=%h,%h", bus.sum_real, bus.sum_im, bus.diff_real, bus.diff_im);
    endtask

    task automatic test_capture;
        int n;
        bus.out_ready = 1'b1;
        drive_pair(32'h3F800000, 32'h40800000, 32'h40000000, 32'h3F000000);
        n = 1;
        while (!bus.out_valid && n < 20) begin
            bus.a_real = $urandom;
            bus.b_im   = $urandom;
            @(negedge clk);
            n++;
        end
        checks++; if ({bus.sum_real, bus.sum_im, bus.diff_real, bus.diff_im} !== {32'h40400000, 32'h40900000, 32'hBF800000, 32'h40600000}) begin
            errors++; $display("FAIL capture got %h %h %h %h want 40400000 40900000 bf800000 40600000", bus.sum_real, bus.sum_im, bus.diff_real, bus.diff_im);
        end
        $display("capture: sum=%h,%h diff=%h,%h", bus.sum_real, bus.sum_im, bus.diff_real, bus.diff_im);
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int k, r, c;
        int acc_t [3];
        k = 0; r = 0; c = 0;
        bus.out_ready = 1'b1;
        while (r < 3 && c < 60) begin
            if (bus.out_valid) begin
                checks++; if ({bus.sum_real, bus.sum_im, bus.diff_real, bus.diff_im} !== {E_SR[r], E_SI[r], E_DR[r], E_DI[r]}) begin
                    errors++; $display("FAIL b2b_result[%0d] got %h %h %h %h want %h %h %h %h", r, bus.sum_real, bus.sum_im, bus.diff_real, bus.diff_im, E_SR[r], E_SI[r], E_DR[r], E_DI[r]);
                end
                $display("b2b[%0d]: sum=%h,%h diff=%h,%h", r, bus.sum_real, bus.sum_im, bus.diff_real, bus.diff_im);
                r++;
            end
            if (bus.in_ready && k < 3) begin
                bus.a_real = P_AR[k]; bus.a_im = P_AI[k];
                bus.b_real = P_BR[k]; bus.b_im = P_BI[k];
                bus.in_valid = 1'b1;
                acc_t[k] = c;
                k++;
            end
            @(negedge clk);
            c++;
        end
        bus.in_valid = 1'b0;
        checks++; if (r != 3) begin errors++; $display("FAIL b2b_count got %0d results want 3", r); end
        for (int i = 1; i < 3; i++) begin
            checks++; if (acc_t[i] - acc_t[i-1] != 6) begin
                errors++; $display("FAIL b2b_spacing[%0d] got %0d cycles want 6", i, acc_t[i] - acc_t[i-1]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_sign_zero;
        int n;
        bus.out_ready = 1'b1;
        drive_pair(32'h40490FDB, 32'h40490FDB, 32'h40490FDB, 32'h40490FDB);
        n = 1;
        while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
        checks++; if (bus.sum_real !== 32'h40C90FDB || bus.sum_im !== 32'h40C90FDB) begin
            errors++; $display("FAIL pi_sum got %h %h want 40c90fdb 40c90fdb", bus.sum_real, bus.sum_im);
        end
        checks++; if (bus.diff_real !== 32'h00000000 || bus.diff_im !== 32'h00000000) begin
            errors++; $display("FAIL pi_diff got %h %h want 00000000 00000000", bus.diff_real, bus.diff_im);
        end
        $display("sign_zero: sum=%h,%h diff=%h,%h", bus.sum_real, bus.sum_im, bus.diff_real, bus.diff_im);
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int n;
        bus.out_ready = 1'b1;
        drive_pair(P_AR[2], P_AI[2], P_BR[2], P_BI[2]);
        repeat (2) @(negedge clk);  // now in DR with both sums written
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_flags got out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
        end
        checks++; if ({bus.sum_real, bus.sum_im, bus.diff_real, bus.diff_im} !== 128'd0) begin
            errors++; $display("FAIL midrst_results got %h %h %h %h want all 0", bus.sum_real, bus.sum_im, bus.diff_real, bus.diff_im);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_pair(P_AR[1], P_AI[1], P_BR[1], P_BI[1]);
        n = 1;
        while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
        checks++; if (n != 5) begin errors++; $display("FAIL midrst_latency got %0d edges want 5", n); end
        checks++; if ({bus.sum_real, bus.sum_im, bus.diff_real, bus.diff_im} !== {E_SR[1], E_SI[1], E_DR[1], E_DI[1]}) begin
            errors++; $display("FAIL midrst_after got %h %h %h %h want %h %h %h %h", bus.sum_real, bus.sum_im, bus.diff_real, bus.diff_im, E_SR[1], E_SI[1], E_DR[1], E_DI[1]);
        end
        $display("reset_mid: recovered sum=%h,%h diff=%h,%h", bus.sum_real, bus.sum_im, bus.diff_real, bus.diff_im);
        @(negedge clk);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a_real    = 32'd0;
        bus.a_im      = 32'd0;
        bus.b_real    = 32'd0;
        bus.b_im      = 32'd0;
        test_reset();
        test_basic();
        test_backpressure();
        test_capture();
        test_back_to_back();
        test_sign_zero();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
